ctrl_exe_pipe: RTL and testbench
================================

// Module: ctrl_exe_pipe
// PURPOSE
//  Parametrised, pipelined control-instruction execute lane: resolves branches/jumps, forwards source operands
//  from NUM_BYPASS bypass channels, and presents the writeback packet LATENCY cycles later with a mispredict flag.
//  Adds over the single-cycle control lane: configurable depth, writeback stall, global flush, self-squash of
//  younger in-flight ops on mispredict, and saturating hardware branch-statistics counters.
// PARAMETERS
//  NUM_BYPASS  4   number of bypass channels checked for each source operand
//  LATENCY     2   cycles from accepted input to wb_valid_o (>=1)
//  DATA_W      32  operand/result width;  PC_W 32  PC width
//  TAG_W       7   physical-register tag width;  SEQ_W 8  sequence-number width (wraps)
//  CNT_W       32  statistics counter width
// PORTS
//  clk            in   1                   clock
//  reset          in   1                   synchronous, active-high reset
//  flush_i        in   1                   core recovery: kill every in-flight op and the input this cycle
//  stall_i        in   1                   writeback not ready: hold whole pipe
//  in_valid_i     in   1                   input op valid (ignored while stall_i)
//  in_seq_i/in_pc_i/in_op_i  in  SEQ_W/PC_W/4  seqNo, PC, op (0 BEQ,1 BNE,2 BLEZ,3 BGTZ,4 BLTZ,5 BGEZ,6 J,7 JAL,8 JR,9 JALR)
//  in_src1_tag_i/in_src2_tag_i  in  TAG_W   physical source tags
//  in_src1_i/in_src2_i   in   DATA_W        register-file source data
//  in_immd_i      in   DATA_W              immediate (word offset / jump index)
//  in_pred_npc_i  in   PC_W                predicted next PC;  in_pred_dir_i in 1 predicted direction
//  in_dest_tag_i  in   TAG_W               link destination;  in_cti_id_i in 4 CTI queue id
//  byp_valid_i    in   NUM_BYPASS          per-channel bypass valid
//  byp_tag_i      in   NUM_BYPASS*TAG_W    per-channel bypass tag (channel k at [k*TAG_W +: TAG_W])
//  byp_data_i     in   NUM_BYPASS*DATA_W   per-channel bypass data
//  wb_valid_o     out  1                   writeback packet valid
//  wb_seq_o/wb_pc_o/wb_dest_tag_o/wb_cti_id_o out  pass-through fields
//  wb_result_o    out  DATA_W              link value (PC+8) for JAL/JALR, else 0
//  wb_npc_o       out  PC_W                computed next PC;  wb_dir_o out 1 computed direction
//  wb_mispred_o   out  1                   wb_npc_o != predicted NPC
//  stat_pred_o/stat_corr_o/stat_cond_o/stat_cond_corr_o  out  CNT_W  resolved / correct / conditional / cond-correct
// BEHAVIOUR
//  Reset: all stage valids 0, all wb_* outputs 0, all stat counters 0. reset dominates flush_i and stall_i.
//  Forwarding (input cycle, comb): srcN = byp_data[k] for lowest k with byp_valid[k] && byp_tag[k]==srcN_tag,
//   else in_srcN_i. Tag 0 is never forwarded (hardwired zero register).
//  Resolve (input cycle): cond branches signed compare per op (BEQ/BNE use src1 vs src2; others src1 vs 0);
//   taken target = pc+8+(immd<<3); not-taken/fallthrough = pc+8; J/JAL target = {pc[PC_W-1:28], immd[24:0],3'b0};
//   JR/JALR target = src1. Jumps: dir=1. All adds truncate to PC_W. Mispredict = (npc != pred_npc).
//  Pipe: LATENCY stage registers; stage 0 captures resolved packet; packet exits stage LATENCY-1 as wb_*.
//   stall_i=1: no stage advances, outputs hold, input not accepted (issue must hold it).
//  Squash: when wb_valid_o && wb_mispred_o && !stall_i, every in-flight stage and the input whose seq is younger
//   than wb_seq_o is invalidated. Younger(a,b) = ((a-b) mod 2^SEQ_W) in [1, 2^(SEQ_W-1)-1]. Older/equal kept.
//  flush_i=1: all stage valids and the input cleared next edge regardless of stall_i; the current wb_* packet is
//   still counted this cycle only if wb_valid_o && !stall_i.
//  Stats: on each cycle with wb_valid_o && !stall_i: pred++; corr++ if !mispred; cond++ and cond_corr++ (if correct)
//   for ops 0-5. Counters saturate at 2^CNT_W-1; never cleared except by reset.
//  Ops 10-15: treated as not-taken, npc=pc+8, result 0; still counted.
// TESTING
//  BEQ pc=0x100, src1=src2=5, immd=4, pred_npc=0x128 -> after LATENCY cycles wb_npc=0x128, dir=1, mispred=0.
//  BNE src1 tag=9 rf=3, byp ch2 tag9=3 and ch0 tag9=7 valid, src2=3 -> ch0 wins, taken, npc=pc+8+(immd<<3).
//  JALR pc=0x200, src1=0x400, pred_npc=0x208 -> npc=0x400, result=0x208, mispred=1; queued younger seq dropped.
//  Mispredict at seq 0xFE with in-flight seq 0x01 and 0xFD -> 0x01 squashed, 0xFD retires (wrap check).
//  stall_i high 3 cycles with valid wb -> outputs constant, stat_pred increments once after release.
//  flush_i with 2 ops in flight then reset mid-stream -> no further wb_valid_o; counters 0 after reset.

Source files
------------

// File: rtl/ctrl_exe_pipe.sv
// Pipelined control-instruction execute lane: bypassed operands, branch/jump resolve, LATENCY-deep
// writeback pipe with stall, flush, mispredict self-squash of younger ops, and saturating branch statistics.
module ctrl_exe_pipe #(
  parameter int NUM_BYPASS = 4,
  parameter int LATENCY    = 2,
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int TAG_W      = 7,
  parameter int SEQ_W      = 8,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush_i,
  input  logic                        stall_i,
  input  logic                        in_valid_i,
  input  logic [SEQ_W-1:0]            in_seq_i,
  input  logic [PC_W-1:0]             in_pc_i,
  input  logic [3:0]                  in_op_i,
  input  logic [TAG_W-1:0]            in_src1_tag_i,
  input  logic [TAG_W-1:0]            in_src2_tag_i,
  input  logic [DATA_W-1:0]           in_src1_i,
  input  logic [DATA_W-1:0]           in_src2_i,
  input  logic [DATA_W-1:0]           in_immd_i,
  input  logic [PC_W-1:0]             in_pred_npc_i,
  input  logic                        in_pred_dir_i,
  input  logic [TAG_W-1:0]            in_dest_tag_i,
  input  logic [3:0]                  in_cti_id_i,
  input  logic [NUM_BYPASS-1:0]       byp_valid_i,
  input  logic [NUM_BYPASS*TAG_W-1:0] byp_tag_i,
  input  logic [NUM_BYPASS*DATA_W-1:0] byp_data_i,
  output logic                        wb_valid_o,
  output logic [SEQ_W-1:0]            wb_seq_o,
  output logic [PC_W-1:0]             wb_pc_o,
  output logic [TAG_W-1:0]            wb_dest_tag_o,
  output logic [3:0]                  wb_cti_id_o,
  output logic [DATA_W-1:0]           wb_result_o,
  output logic [PC_W-1:0]             wb_npc_o,
  output logic                        wb_dir_o,
  output logic                        wb_mispred_o,
  output logic [CNT_W-1:0]            stat_pred_o,
  output logic [CNT_W-1:0]            stat_corr_o,
  output logic [CNT_W-1:0]            stat_cond_o,
  output logic [CNT_W-1:0]            stat_cond_corr_o
);

  typedef enum logic [3:0] {
    OP_BEQ = 4'd0, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ, OP_J, OP_JAL, OP_JR, OP_JALR
  } ctrlOp_e;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [PC_W-1:0]   pc;
    logic [TAG_W-1:0]  destTag;
    logic [3:0]        ctiId;
    logic [DATA_W-1:0] result;
    logic [PC_W-1:0]   npc;
    logic              dir;
    logic              mispred;
    logic              isCond;
  } wbPkt_t;

  // Sequence numbers wrap, so age is judged on the modular difference.
  function automatic logic isYounger(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] diff;
    diff = a - b;
    return (diff != '0) && !diff[SEQ_W-1];
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic                unusedPredDir;
  logic [DATA_W-1:0]   src1, src2;
  logic [PC_W-1:0]     pcPlus8, brTarget, jTarget;
  logic                taken;
  wbPkt_t              resolved;
  wbPkt_t              stagePkt [LATENCY];
  logic [LATENCY-1:0]  stageValid;
  logic                wbFire, squashYounger;

  // Direction prediction does not affect resolution; mispredict is judged on the next PC only.
  assign unusedPredDir = in_pred_dir_i;

  // Walk channels from highest to lowest so the lowest matching channel is written last and wins.
  always_comb begin
    src1 = in_src1_i;
    src2 = in_src2_i;
    for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
      if (byp_valid_i[k] && in_src1_tag_i != '0 && byp_tag_i[k*TAG_W +: TAG_W] == in_src1_tag_i)
        src1 = byp_data_i[k*DATA_W +: DATA_W];
      if (byp_valid_i[k] && in_src2_tag_i != '0 && byp_tag_i[k*TAG_W +: TAG_W] == in_src2_tag_i)
        src2 = byp_data_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    pcPlus8          = in_pc_i + PC_W'(8);
    brTarget         = pcPlus8 + PC_W'(in_immd_i << 3);
    jTarget          = {in_pc_i[PC_W-1:28], in_immd_i[24:0], 3'b000};
    taken            = 1'b0;
    resolved         = '0;
    resolved.seq     = in_seq_i;
    resolved.pc      = in_pc_i;
    resolved.destTag = in_dest_tag_i;
    resolved.ctiId   = in_cti_id_i;
    resolved.npc     = pcPlus8;
    case (in_op_i)
      OP_BEQ:  begin resolved.isCond = 1'b1; taken = (src1 == src2); end
      OP_BNE:  begin resolved.isCond = 1'b1; taken = (src1 != src2); end
      OP_BLEZ: begin resolved.isCond = 1'b1; taken = src1[DATA_W-1] || (src1 == '0); end
      OP_BGTZ: begin resolved.isCond = 1'b1; taken = !src1[DATA_W-1] && (src1 != '0); end
      OP_BLTZ: begin resolved.isCond = 1'b1; taken = src1[DATA_W-1]; end
      OP_BGEZ: begin resolved.isCond = 1'b1; taken = !src1[DATA_W-1]; end
      OP_J:    begin resolved.dir = 1'b1; resolved.npc = jTarget; end
      OP_JAL:  begin
        resolved.dir    = 1'b1;
        resolved.npc    = jTarget;
        resolved.result = DATA_W'(pcPlus8);
      end
      OP_JR:   begin resolved.dir = 1'b1; resolved.npc = PC_W'(src1); end
      OP_JALR: begin
        resolved.dir    = 1'b1;
        resolved.npc    = PC_W'(src1);
        resolved.result = DATA_W'(pcPlus8);
      end
      default: ;
    endcase
    if (resolved.isCond) begin
      resolved.dir = taken;
      if (taken) resolved.npc = brTarget;
    end
    resolved.mispred = (resolved.npc != in_pred_npc_i);
  end

  assign wbFire        = wb_valid_o && !stall_i;
  assign squashYounger = wbFire && wb_mispred_o;

  // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      stageValid <= '0;
      // NOTE: packet payload is reset too, so the wb_* fields read zero after reset, not only wb_valid_o.
      for (int i = 0; i < LATENCY; i++) stagePkt[i] <= '0;
    end else if (flush_i) begin
      stageValid <= '0;
    end else if (!stall_i) begin
      stageValid[0] <= in_valid_i && !(squashYounger && isYounger(in_seq_i, wb_seq_o));
      stagePkt[0]   <= resolved;
      for (int i = 1; i < LATENCY; i++) begin
        stageValid[i] <= stageValid[i-1] && !(squashYounger && isYounger(stagePkt[i-1].seq, wb_seq_o));
        stagePkt[i]   <= stagePkt[i-1];
      end
    end
  end

  assign wb_valid_o    = stageValid[LATENCY-1];
  assign wb_seq_o      = stagePkt[LATENCY-1].seq;
  assign wb_pc_o       = stagePkt[LATENCY-1].pc;
  assign wb_dest_tag_o = stagePkt[LATENCY-1].destTag;
  assign wb_cti_id_o   = stagePkt[LATENCY-1].ctiId;
  assign wb_result_o   = stagePkt[LATENCY-1].result;
  assign wb_npc_o      = stagePkt[LATENCY-1].npc;
  assign wb_dir_o      = stagePkt[LATENCY-1].dir;
  assign wb_mispred_o  = stagePkt[LATENCY-1].mispred;

  // A packet leaving during a flush cycle still counts; a stalled packet counts once, on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pred_o      <= '0;
      stat_corr_o      <= '0;
      stat_cond_o      <= '0;
      stat_cond_corr_o <= '0;
    end else if (wbFire) begin
      stat_pred_o <= satInc(stat_pred_o);
      if (!wb_mispred_o) stat_corr_o <= satInc(stat_corr_o);
      if (stagePkt[LATENCY-1].isCond) begin
        stat_cond_o <= satInc(stat_cond_o);
        if (!wb_mispred_o) stat_cond_corr_o <= satInc(stat_cond_corr_o);
      end
    end
  end

endmodule

// File: tb/tb_ctrl_exe_pipe.sv
// Self-checking bench for ctrl_exe_pipe: a timestamped queue model checked every cycle,
// plus directed vectors with hand-computed literals for forwarding, squash, wrap, stall, flush, saturation, reset.
module tb_ctrl_exe_pipe;
  localparam int NB  = 4;
  localparam int LAT = 2;
  localparam int DW  = 32;
  localparam int PW  = 32;
  localparam int TW  = 7;
  localparam int SW  = 8;
  localparam int CW  = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic            clk, reset, flush_i, stall_i, in_valid_i, in_pred_dir_i;
  logic [SW-1:0]   in_seq_i;
  logic [PW-1:0]   in_pc_i, in_pred_npc_i;
  logic [3:0]      in_op_i, in_cti_id_i;
  logic [TW-1:0]   in_src1_tag_i, in_src2_tag_i, in_dest_tag_i;
  logic [DW-1:0]   in_src1_i, in_src2_i, in_immd_i;
  logic [NB-1:0]   byp_valid_i;
  logic [NB*TW-1:0] byp_tag_i;
  logic [NB*DW-1:0] byp_data_i;
  logic            wb_valid_o, wb_dir_o, wb_mispred_o;
  logic [SW-1:0]   wb_seq_o;
  logic [PW-1:0]   wb_pc_o, wb_npc_o;
  logic [TW-1:0]   wb_dest_tag_o;
  logic [3:0]      wb_cti_id_o;
  logic [DW-1:0]   wb_result_o;
  logic [CW-1:0]   stat_pred_o, stat_corr_o, stat_cond_o, stat_cond_corr_o;

  ctrl_exe_pipe #(
    .NUM_BYPASS(NB), .LATENCY(LAT), .DATA_W(DW), .PC_W(PW), .TAG_W(TW), .SEQ_W(SW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .stall_i(stall_i), .in_valid_i(in_valid_i),
    .in_seq_i(in_seq_i), .in_pc_i(in_pc_i), .in_op_i(in_op_i),
    .in_src1_tag_i(in_src1_tag_i), .in_src2_tag_i(in_src2_tag_i),
    .in_src1_i(in_src1_i), .in_src2_i(in_src2_i), .in_immd_i(in_immd_i),
    .in_pred_npc_i(in_pred_npc_i), .in_pred_dir_i(in_pred_dir_i),
    .in_dest_tag_i(in_dest_tag_i), .in_cti_id_i(in_cti_id_i),
    .byp_valid_i(byp_valid_i), .byp_tag_i(byp_tag_i), .byp_data_i(byp_data_i),
    .wb_valid_o(wb_valid_o), .wb_seq_o(wb_seq_o), .wb_pc_o(wb_pc_o), .wb_dest_tag_o(wb_dest_tag_o),
    .wb_cti_id_o(wb_cti_id_o), .wb_result_o(wb_result_o), .wb_npc_o(wb_npc_o), .wb_dir_o(wb_dir_o),
    .wb_mispred_o(wb_mispred_o), .stat_pred_o(stat_pred_o), .stat_corr_o(stat_corr_o),
    .stat_cond_o(stat_cond_o), .stat_cond_corr_o(stat_cond_corr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checksTotal  = 0;
  int checksPassed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted op becomes visible at writeback once the pipe has advanced LAT times after it.
  typedef struct {
    logic [SW-1:0] seq;
    logic [PW-1:0] pc;
    logic [TW-1:0] dest;
    logic [3:0]    cti;
    logic [DW-1:0] result;
    logic [PW-1:0] npc;
    logic          dir;
    logic          mispred;
    bit            isCond;
    int            visibleAt;
  } item_t;

  item_t q[$];
  int adv = 0;
  int mPred = 0, mCorr = 0, mCond = 0, mCondCorr = 0;

  function automatic bit younger(input logic [SW-1:0] a, input logic [SW-1:0] b);
    int d;
    d = (int'(a) - int'(b) + 256) % 256;
    return (d >= 1) && (d <= 127);
  endfunction

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  function automatic logic [DW-1:0] pickSrc(input logic [TW-1:0] tag, input logic [DW-1:0] rf);
    if (tag == 0) return rf;
    for (int k = 0; k < NB; k++)
      if (byp_valid_i[k] && byp_tag_i[k*TW +: TW] == tag) return byp_data_i[k*DW +: DW];
    return rf;
  endfunction

  function automatic item_t resolveModel();
    item_t it;
    logic [DW-1:0] a, b;
    logic [PW-1:0] fall;
    int sa, op;
    bit taken;
    a = pickSrc(in_src1_tag_i, in_src1_i);
    b = pickSrc(in_src2_tag_i, in_src2_i);
    sa = $signed(a);
    op = int'(in_op_i);
    fall = in_pc_i + 32'd8;
    taken = 0;
    it.seq = in_seq_i; it.pc = in_pc_i; it.dest = in_dest_tag_i; it.cti = in_cti_id_i;
    it.result = '0; it.npc = fall; it.dir = 1'b0; it.isCond = 0; it.visibleAt = 0;
    if (op <= 5) begin
      it.isCond = 1;
      case (op)
        0: taken = (a == b);
        1: taken = (a != b);
        2: taken = (sa <= 0);
        3: taken = (sa > 0);
        4: taken = (sa < 0);
        default: taken = (sa >= 0);
      endcase
      it.dir = taken;
      if (taken) it.npc = fall + (in_immd_i << 3);
    end else if (op == 6 || op == 7) begin
      it.dir = 1'b1;
      it.npc = (in_pc_i & 32'hF000_0000) | ((in_immd_i & 32'h01FF_FFFF) << 3);
    end else if (op == 8 || op == 9) begin
      it.dir = 1'b1;
      it.npc = a;
    end
    if (op == 7 || op == 9) it.result = fall;
    it.mispred = (it.npc != in_pred_npc_i);
    return it;
  endfunction

  always @(posedge clk) begin
    int wi;
    bit fire, kill;
    logic [SW-1:0] wseq;
    item_t nw;
    wi = -1; kill = 0; wseq = '0;
    if (reset) begin
      q.delete();
      adv = 0; mPred = 0; mCorr = 0; mCond = 0; mCondCorr = 0;
    end else begin
      for (int i = 0; i < q.size(); i++) if (q[i].visibleAt == adv) wi = i;
      fire = (wi >= 0) && !stall_i;
      if (fire) begin
        mPred = sat(mPred);
        if (!q[wi].mispred) mCorr = sat(mCorr);
        if (q[wi].isCond) begin
          mCond = sat(mCond);
          if (!q[wi].mispred) mCondCorr = sat(mCondCorr);
        end
        kill = q[wi].mispred;
        wseq = q[wi].seq;
        q.delete(wi);
        if (kill)
          for (int i = q.size() - 1; i >= 0; i--) if (younger(q[i].seq, wseq)) q.delete(i);
      end
      if (flush_i) q.delete();
      else if (!stall_i && in_valid_i && !(kill && younger(in_seq_i, wseq))) begin
        nw = resolveModel();
        nw.visibleAt = adv + LAT;
        q.push_back(nw);
      end
      if (!stall_i) adv++;
    end
  end

  // Compare DUT against the model shortly after every active edge.
  always @(posedge clk) begin
    int wi;
    #2;
    wi = -1;
    for (int i = 0; i < q.size(); i++) if (q[i].visibleAt == adv) wi = i;
    check("m_wb_valid", wb_valid_o, (wi >= 0) ? 64'd1 : 64'd0);
    if (wi >= 0) begin
      check("m_wb_seq",     wb_seq_o,      q[wi].seq);
      check("m_wb_pc",      wb_pc_o,       q[wi].pc);
      check("m_wb_dest",    wb_dest_tag_o, q[wi].dest);
      check("m_wb_cti",     wb_cti_id_o,   q[wi].cti);
      check("m_wb_result",  wb_result_o,   q[wi].result);
      check("m_wb_npc",     wb_npc_o,      q[wi].npc);
      check("m_wb_dir",     wb_dir_o,      q[wi].dir);
      check("m_wb_mispred", wb_mispred_o,  q[wi].mispred);
    end
    check("m_stat_pred",      stat_pred_o,      mPred);
    check("m_stat_corr",      stat_corr_o,      mCorr);
    check("m_stat_cond",      stat_cond_o,      mCond);
    check("m_stat_cond_corr", stat_cond_corr_o, mCondCorr);
  end

  // ---------------- stimulus ----------------
  task automatic setOp(input logic [SW-1:0] seq, input logic [3:0] op, input logic [PW-1:0] pc,
                       input logic [TW-1:0] t1, input logic [DW-1:0] s1,
                       input logic [TW-1:0] t2, input logic [DW-1:0] s2,
                       input logic [DW-1:0] immd, input logic [PW-1:0] pred);
    in_valid_i = 1'b1; in_seq_i = seq; in_op_i = op; in_pc_i = pc;
    in_src1_tag_i = t1; in_src1_i = s1; in_src2_tag_i = t2; in_src2_i = s2;
    in_immd_i = immd; in_pred_npc_i = pred; in_pred_dir_i = 1'b0;
    in_dest_tag_i = seq[6:0] ^ 7'h2A; in_cti_id_i = seq[3:0];
  endtask

  task automatic issue(input logic [SW-1:0] seq, input logic [3:0] op, input logic [PW-1:0] pc,
                       input logic [TW-1:0] t1, input logic [DW-1:0] s1,
                       input logic [TW-1:0] t2, input logic [DW-1:0] s2,
                       input logic [DW-1:0] immd, input logic [PW-1:0] pred);
    setOp(seq, op, pc, t1, s1, t2, s2, immd, pred);
    @(negedge clk);
    in_valid_i = 1'b0;
    byp_valid_i = '0;
  endtask

  task automatic waitWb(input string name);
    int n;
    n = 0;
    while (!wb_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_arrive"}, wb_valid_o, 1);
  endtask

  task automatic expectIdle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check(name, wb_valid_o, 0);
      @(negedge clk);
    end
  endtask

  int opsTab [16] = '{0, 1, 2, 3, 4, 5, 2, 3, 4, 5, 6, 7, 8, 9, 12, 15};
  int valsTab[16] = '{5, 5, -1, 0, 0, -7, 3, -2, -9, 4, 1, 1, 32'h5000, 32'h6000, 0, 0};
  int predBefore;

  initial begin
    reset = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    setOp('0, '0, '0, '0, '0, '0, '0, '0, '0);
    in_valid_i = 1'b0;
    byp_valid_i = '0; byp_tag_i = '0; byp_data_i = '0;
    repeat (2) @(negedge clk);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_npc",   wb_npc_o,   0);
    check("rst_wb_seq",   wb_seq_o,   0);
    check("rst_wb_res",   wb_result_o, 0);
    check("rst_stat_pred", stat_pred_o, 0);
    check("rst_stat_cond", stat_cond_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // BEQ equal, taken: 0x100+8+(4<<3) = 0x128
    issue(8'h01, 4'd0, 32'h100, 7'd0, 32'd5, 7'd0, 32'd5, 32'd4, 32'h128);
    waitWb("beq");
    check("beq_npc",     wb_npc_o,      32'h128);
    check("beq_dir",     wb_dir_o,      1);
    check("beq_mispred", wb_mispred_o,  0);
    check("beq_result",  wb_result_o,   0);
    check("beq_dest",    wb_dest_tag_o, 7'h2B);
    @(negedge clk);

    // BNE: ch0 (7) beats ch2 (3) for tag 9, so 7 != 3 -> taken, 0x300+8+0x10 = 0x318
    byp_valid_i = 4'b0101;
    byp_tag_i   = {7'd0, 7'd9, 7'd0, 7'd9};
    byp_data_i  = {32'd0, 32'd3, 32'd0, 32'd7};
    issue(8'h02, 4'd1, 32'h300, 7'd9, 32'd3, 7'd0, 32'd3, 32'd2, 32'h318);
    waitWb("bne_fwd");
    check("bne_npc",     wb_npc_o,     32'h318);
    check("bne_dir",     wb_dir_o,     1);
    check("bne_mispred", wb_mispred_o, 0);
    @(negedge clk);

    // Tag 0 must not be forwarded: src1 stays 10, equals src2 -> taken, 0x410
    byp_valid_i = 4'b0010;
    byp_tag_i   = '0;
    byp_data_i  = {32'd0, 32'd0, 32'h55, 32'd0};
    issue(8'h03, 4'd0, 32'h400, 7'd0, 32'd10, 7'd5, 32'd10, 32'd1, 32'h410);
    waitWb("tag0");
    check("tag0_npc", wb_npc_o, 32'h410);
    @(negedge clk);

    // JALR mispredict; the two following younger ops are squashed (stage and input)
    issue(8'h10, 4'd9, 32'h200, 7'd0, 32'h400, 7'd0, 32'd0, 32'd0, 32'h208);
    issue(8'h11, 4'd0, 32'h210, 7'd0, 32'd1, 7'd0, 32'd1, 32'd0, 32'h218);
    check("jalr_valid",   wb_valid_o,   1);
    check("jalr_seq",     wb_seq_o,     8'h10);
    check("jalr_npc",     wb_npc_o,     32'h400);
    check("jalr_result",  wb_result_o,  32'h208);
    check("jalr_mispred", wb_mispred_o, 1);
    issue(8'h12, 4'd6, 32'h220, 7'd0, 32'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    expectIdle("jalr_squash", 4);

    // Wrap: mispredict at 0xFE kills 0x01 (younger), keeps 0xFD (older). J target = 0x10<<3 = 0x80
    issue(8'hFE, 4'd8, 32'h900, 7'd0, 32'h500, 7'd0, 32'd0, 32'd0, 32'h908);
    issue(8'h01, 4'd6, 32'h1000, 7'd0, 32'd0, 7'd0, 32'd0, 32'h10, 32'h80);
    check("wrap_fe_mispred", wb_mispred_o, 1);
    issue(8'hFD, 4'd6, 32'h1000, 7'd0, 32'd0, 7'd0, 32'd0, 32'h10, 32'h80);
    check("wrap_gap", wb_valid_o, 0);
    @(negedge clk);
    check("wrap_fd_valid", wb_valid_o, 1);
    check("wrap_fd_seq",   wb_seq_o,   8'hFD);
    check("wrap_fd_npc",   wb_npc_o,   32'h80);
    @(negedge clk);
    check("wrap_done", wb_valid_o, 0);

    // Mixed back-to-back ops, checked by the model
    for (int i = 0; i < 16; i++)
      issue(8'(8'h20 + i), 4'(opsTab[i]), 32'(32'h2000 + i * 32'h40), 7'd0, 32'(valsTab[i]),
            7'd0, 32'd5, 32'(i + 1), 32'(32'h2008 + i * 32'h40));
    repeat (4) @(negedge clk);

    // Stall: BGTZ 5>0 taken -> 0x600+8+0x18 = 0x620; held 3 cycles, counted once on release
    issue(8'h50, 4'd3, 32'h600, 7'd0, 32'd5, 7'd0, 32'd0, 32'd3, 32'h620);
    waitWb("stall");
    predBefore = mPred;
    stall_i = 1'b1;
    setOp(8'h51, 4'd6, 32'h700, 7'd0, 32'd0, 7'd0, 32'd0, 32'd1, 32'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", wb_valid_o, 1);
      check("stall_npc",   wb_npc_o,   32'h620);
      check("stall_seq",   wb_seq_o,   8'h50);
      check("stall_pred",  stat_pred_o, predBefore);
    end
    stall_i = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk);
    check("stall_release_pred", stat_pred_o, predBefore + 1);
    expectIdle("stall_no_accept", 3);

    // Unused op 12: not-taken fallthrough, result 0
    issue(8'h58, 4'd12, 32'h700, 7'd0, 32'd9, 7'd0, 32'd0, 32'd7, 32'h708);
    waitWb("op12");
    check("op12_npc", wb_npc_o, 32'h708);
    check("op12_dir", wb_dir_o, 0);
    @(negedge clk);

    // Flush with two ops in flight plus a new input
    issue(8'h60, 4'd6, 32'h3000, 7'd0, 32'd0, 7'd0, 32'd0, 32'h20, 32'h100);
    issue(8'h61, 4'd6, 32'h3000, 7'd0, 32'd0, 7'd0, 32'd0, 32'h20, 32'h100);
    flush_i = 1'b1;
    setOp(8'h62, 4'd6, 32'h3000, 7'd0, 32'd0, 7'd0, 32'd0, 32'h20, 32'h100);
    @(negedge clk);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    expectIdle("flush", 5);

    // Saturation: 70 correctly predicted not-taken BEQs
    for (int i = 0; i < 70; i++)
      issue(8'(8'h70 + i), 4'd0, 32'(32'h4000 + i * 16), 7'd0, 32'd1, 7'd0, 32'd2, 32'd3,
            32'(32'h4008 + i * 16));
    repeat (3) @(negedge clk);
    check("sat_pred",      stat_pred_o,      CNT_MAX);
    check("sat_corr",      stat_corr_o,      CNT_MAX);
    check("sat_cond",      stat_cond_o,      CNT_MAX);
    check("sat_cond_corr", stat_cond_corr_o, CNT_MAX);

    // Reset mid-stream, dominating stall and flush
    issue(8'hA0, 4'd6, 32'h5000, 7'd0, 32'd0, 7'd0, 32'd0, 32'd1, 32'd8);
    reset = 1'b1; stall_i = 1'b1; flush_i = 1'b1;
    setOp(8'hA1, 4'd6, 32'h5000, 7'd0, 32'd0, 7'd0, 32'd0, 32'd1, 32'd8);
    repeat (2) @(negedge clk);
    check("rst2_valid", wb_valid_o, 0);
    check("rst2_npc",   wb_npc_o,   0);
    check("rst2_pred",  stat_pred_o, 0);
    check("rst2_corr",  stat_corr_o, 0);
    reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    expectIdle("rst2_idle", 4);
    check("rst2_cond", stat_cond_o, 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
